// File: rtl/sel_arb_pkg.sv
// Shared types and default sizing for the round-robin select arbiter.
package sel_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned N_REQ_DEF  = 4;

endpackage

// File: rtl/sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i.
module rr_pick
  import sel_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         mask_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         win_o,
  output logic                     any_o
);

  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_win;
  logic [2*N_REQ-1:0] dbl_dn;
  logic [2*N_REQ-1:0] dbl_up;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    elig    = req_i & ~mask_i;
    dbl_dn  = {elig, elig} >> ptr_i;
    rot     = dbl_dn[N_REQ-1:0];
    rot_win = rot & (~rot + 1'b1);
    dbl_up  = {rot_win, rot_win} << ptr_i;
    win_o   = dbl_up[2*N_REQ-1:N_REQ];
    any_o   = |elig;
  end

endmodule

// File: rtl/sel_arbiter.sv
// Round-robin N-way arbiter with registered one-hot grant and valid/ready output word.
// Define SEL_ARB_IDLE_ZERO_EN to clear o_y on the edge that returns to IDLE.
module sel_arbiter
  import sel_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_REQ  = N_REQ_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [DATA_W-1:0]       o_y,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int unsigned PW = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [N_REQ-1:0]  win;
  logic              any;
  logic [DATA_W-1:0] win_data;
  logic [PW-1:0]     win_idx;
  logic              take;

  // The currently pulsing grant is masked so a not-yet-dropped request is not served twice.
  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i  (i_req),
    .mask_i (gnt_q),
    .ptr_i  (ptr_q),
    .win_o  (win),
    .any_o  (any)
  );

  always_comb begin
    win_data = '0;
    win_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win[k]) begin
        win_data = i_data[k*DATA_W +: DATA_W];
        win_idx  = PW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    y_d     = y_q;
    ptr_d   = ptr_q;
    take    = (state_q == IDLE) || i_ready;

    if (take) begin
      if (any) begin
        state_d = BUSY;
        gnt_d   = win;
        y_d     = win_data;
        ptr_d   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = IDLE;
`ifdef SEL_ARB_IDLE_ZERO_EN
        if (state_q == BUSY) begin
          y_d = '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      y_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_y     = y_q;
  assign o_valid = (state_q == BUSY);

endmodule
